// File: rtl/fifo_pkg.sv
// Shared constants, counter-width helper and status grouping for the parametrised FIFO.
package fifo_pkg;

  localparam int DEF_BUF_WIDTH  = 4;
  localparam int DEF_DATA_WIDTH = 8;

  // The occupancy counter needs one extra bit so it can hold exactly 2**bw.
  function automatic int cnt_w(input int bw);
    return bw + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int BUF_WIDTH  = DEF_BUF_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BUF_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [BUF_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**BUF_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a simultaneous write to rd_addr returns the old word.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with runtime almost-full/almost-empty thresholds.
// Define FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow ports.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int BUF_WIDTH  = DEF_BUF_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic [BUF_WIDTH:0]    af_thr,
  input  logic [BUF_WIDTH:0]    ae_thr,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  rd_valid,
  output logic [BUF_WIDTH:0]    fifo_counter,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic                  almost_empty,
  output logic                  almost_full
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int CW       = cnt_w(BUF_WIDTH);
  localparam int BUF_SIZE = 2**BUF_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_SIZE);

  logic [BUF_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                 push_ok, pop_ok;
  fifo_status_t         status;

  assign status.empty        = (fifo_counter == '0);
  assign status.full         = (fifo_counter == FULL_CNT);
  assign status.almost_empty = (fifo_counter <= ae_thr);
  assign status.almost_full  = (fifo_counter >= af_thr);

  assign buf_empty    = status.empty;
  assign buf_full     = status.full;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;

  // A pop frees a slot in the same edge, so a push at full is still accepted.
  assign push_ok = wr_en & (~status.full | rd_en);
  assign pop_ok  = rd_en & ~status.empty;

  fifo_mem #(
    .BUF_WIDTH  (BUF_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_ok & ~rst),
    .wr_addr (wr_ptr),
    .wr_data (buf_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (buf_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + BUF_WIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + BUF_WIDTH'(1);
      if (push_ok && !pop_ok)      fifo_counter <= fifo_counter + CW'(1);
      else if (pop_ok && !push_ok) fifo_counter <= fifo_counter - CW'(1);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !push_ok)      overflow  <= 1'b1;
      if (rd_en && status.empty)  underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (BUF_WIDTH=4, DATA_WIDTH=8): vector table,
// directed corner sequences and random traffic against a queue-based model.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] buf_in = '0;
  logic [4:0] af_thr = 5'd14;
  logic [4:0] ae_thr = 5'd3;
  logic [7:0] buf_out;
  logic       rd_valid;
  logic [4:0] fifo_counter;
  logic       buf_empty, buf_full, almost_empty, almost_full;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  always #5 clk = ~clk;

  fifo_param #(.BUF_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .buf_in       (buf_in),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .buf_out      (buf_out),
    .rd_valid     (rd_valid),
    .fifo_counter (fifo_counter),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural reference: a queue holding the stored words in order.
  logic [7:0] q[$];
  logic [7:0] m_out = '0;
  logic       m_vld = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic rd, input logic [7:0] d);
    bit full, empty, push_ok, pop_ok;
    if (r) begin
      q.delete();
      m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      full    = (q.size() == 16);
      empty   = (q.size() == 0);
      push_ok = w && (!full || rd);
      pop_ok  = rd && !empty;
      if (w && !push_ok) m_ovf = 1'b1;
      if (rd && empty)   m_udf = 1'b1;
      m_vld = pop_ok;
      if (pop_ok)  m_out = q.pop_front();
      if (push_ok) q.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 64'(fifo_counter), 64'(q.size()));
    chk({tag, ".out"},   64'(buf_out),      64'(m_out));
    chk({tag, ".vld"},   64'(rd_valid),     64'(m_vld));
    chk({tag, ".empty"}, 64'(buf_empty),    64'(q.size() == 0));
    chk({tag, ".full"},  64'(buf_full),     64'(q.size() == 16));
    chk({tag, ".ae"},    64'(almost_empty), 64'(q.size() <= int'(ae_thr)));
    chk({tag, ".af"},    64'(almost_full),  64'(q.size() >= int'(af_thr)));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, ".ovf"},   64'(overflow),     64'(m_ovf));
    chk({tag, ".udf"},   64'(underflow),    64'(m_udf));
`endif
  endtask

  // Apply one cycle of inputs, advance the model with it, sample #1 after the edge.
  task automatic cyc(input string tag, input logic r, input logic w, input logic rd,
                     input logic [7:0] d);
    rst = r; wr_en = w; rd_en = rd; buf_in = d;
    @(posedge clk);
    model_edge(r, w, rd, d);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic       r, w, rd;
    logic [7:0] d;
    logic [4:0] cnt;
    logic [7:0] out;
    logic       vld;
    logic       emp;
  } vec_t;

  vec_t vt[10];

  initial begin
    // Table: empty-FIFO push/pop interplay with hand-derived expectations.
    vt[0] = '{r:1, w:0, rd:0, d:8'h00, cnt:0, out:8'h00, vld:0, emp:1};
    vt[1] = '{r:0, w:1, rd:1, d:8'h3C, cnt:1, out:8'h00, vld:0, emp:0};
    vt[2] = '{r:0, w:0, rd:1, d:8'h00, cnt:0, out:8'h3C, vld:1, emp:1};
    vt[3] = '{r:0, w:0, rd:1, d:8'h00, cnt:0, out:8'h3C, vld:0, emp:1};
    vt[4] = '{r:0, w:1, rd:0, d:8'h5A, cnt:1, out:8'h3C, vld:0, emp:0};
    vt[5] = '{r:0, w:1, rd:0, d:8'h6B, cnt:2, out:8'h3C, vld:0, emp:0};
    vt[6] = '{r:0, w:1, rd:1, d:8'h7C, cnt:2, out:8'h5A, vld:1, emp:0};
    vt[7] = '{r:0, w:0, rd:1, d:8'h00, cnt:1, out:8'h6B, vld:1, emp:0};
    vt[8] = '{r:0, w:0, rd:1, d:8'h00, cnt:0, out:8'h7C, vld:1, emp:1};
    vt[9] = '{r:0, w:0, rd:0, d:8'h00, cnt:0, out:8'h7C, vld:0, emp:1};

    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("vec%0d", i), vt[i].r, vt[i].w, vt[i].rd, vt[i].d);
      chk($sformatf("vec%0d.cnt", i), 64'(fifo_counter), 64'(vt[i].cnt));
      chk($sformatf("vec%0d.out", i), 64'(buf_out),      64'(vt[i].out));
      chk($sformatf("vec%0d.vld", i), 64'(rd_valid),     64'(vt[i].vld));
      chk($sformatf("vec%0d.emp", i), 64'(buf_empty),    64'(vt[i].emp));
`ifdef FIFO_ERR_FLAGS_EN
      if (i == 1) chk("vec1.underflow", 64'(underflow), 64'(1));
`endif
    end

    // Fill 15 words, watching almost_full rise at 14 with af_thr=14.
    cyc("rst_a", 1, 0, 0, 8'h00);
    chk("rst.af", 64'(almost_full), 64'(0));
    chk("rst.ae", 64'(almost_empty), 64'(1));
    for (int i = 0; i < 15; i++) begin
      cyc($sformatf("fill%0d", i), 0, 1, 0, 8'h11 + 8'(i));
      if (i == 12) chk("af_below_14", 64'(almost_full), 64'(0));
      if (i == 13) chk("af_at_14",    64'(almost_full), 64'(1));
    end
    chk("fill15.count", 64'(fifo_counter), 64'(15));
    chk("fill15.full",  64'(buf_full),     64'(0));

    // Fill to 16 then hammer wr_en with 0xEE.
    cyc("fill16", 0, 1, 0, 8'h20);
    for (int i = 0; i < 3; i++) cyc($sformatf("ovf%0d", i), 0, 1, 0, 8'hEE);
    chk("ovf.count", 64'(fifo_counter), 64'(16));
    chk("ovf.full",  64'(buf_full),     64'(1));
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf.flag",  64'(overflow),     64'(1));
`endif

    // Push and pop together at full: count holds, head word comes out.
    cyc("fullrw", 0, 1, 1, 8'hA5);
    chk("fullrw.count", 64'(fifo_counter), 64'(16));
    chk("fullrw.out",   64'(buf_out),      64'(8'h11));
    for (int i = 0; i < 16; i++) begin
      cyc($sformatf("drain%0d", i), 0, 0, 1, 8'h00);
      chk($sformatf("drain%0d.word", i), 64'(buf_out),
          64'((i < 15) ? 8'h12 + 8'(i) : 8'hA5));
    end
    chk("drain.empty", 64'(buf_empty), 64'(1));

    // Reset in the same cycle as a push and pop discards both.
    for (int i = 0; i < 5; i++) cyc($sformatf("pre%0d", i), 0, 1, 0, 8'h40 + 8'(i));
    cyc("rst_rw", 1, 1, 1, 8'h99);
    chk("rst_rw.count", 64'(fifo_counter), 64'(0));
    chk("rst_rw.out",   64'(buf_out),      64'(0));
    chk("rst_rw.empty", 64'(buf_empty),    64'(1));
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_rw.ovf",   64'(overflow),     64'(0));
    chk("rst_rw.udf",   64'(underflow),    64'(0));
`endif
    cyc("post_push", 0, 1, 0, 8'h77);
    cyc("post_pop",  0, 0, 1, 8'h00);
    chk("post_pop.out", 64'(buf_out), 64'(8'h77));

    // Threshold sweep at count 3 with no clock edge between changes.
    for (int i = 0; i < 3; i++) cyc($sformatf("th%0d", i), 0, 1, 0, 8'h30 + 8'(i));
    wr_en = 1'b0; rd_en = 1'b0;
    ae_thr = 5'd0;  #1; chk("ae_thr0",  64'(almost_empty), 64'(0));
    ae_thr = 5'd3;  #1; chk("ae_thr3",  64'(almost_empty), 64'(1));
    ae_thr = 5'd16; #1; chk("ae_thr16", 64'(almost_empty), 64'(1));
    af_thr = 5'd0;  #1; chk("af_thr0",  64'(almost_full),  64'(1));
    af_thr = 5'd4;  #1; chk("af_thr4",  64'(almost_full),  64'(0));

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int unsigned bias;
      bias = ((i / 200) % 2 == 0) ? 75 : 25;
      if (i % 97 == 0) begin
        af_thr = 5'($urandom_range(0, 17));
        ae_thr = 5'($urandom_range(0, 17));
      end
      cyc($sformatf("rnd%0d", i),
          $urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < bias,
          $urandom_range(0, 99) < (100 - bias),
          8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
